trail_writer: RTL and testbench

TRAIL_WRITER -- requirements
Module: trail_writer

---
 rtl/trail_writer_pkg.sv | 31 +++
 rtl/trail_writer_row_bit_patch.sv | 30 +++
 rtl/trail_writer.sv | 163 ++++++++++++++++
 tb/tb_trail_writer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trail_writer_pkg.sv
// Shared definitions for the trail writer and the shading stage:
// pixel codes, default map size and the writer FSM encoding.
package trail_writer_pkg;

   localparam int MAP_COLS_DEF = 800;
   localparam int MAP_ROWS_DEF = 600;
   localparam int COORD_W      = 10;

   // Two-plane pixel code, written as {msb, lsb}.
   typedef enum logic [1:0] {
      PIX_UNSHADED = 2'b00,
      PIX_UNKNOWN  = 2'b01,
      PIX_TRAIL    = 2'b10,
      PIX_BORDER   = 2'b11
   } pix_code_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_CHECK,
      ST_WRITE
   } tw_state_e;

   function automatic logic coord_in_map(input logic [COORD_W-1:0] x,
                                         input logic [COORD_W-1:0] y,
                                         input int cols,
                                         input int rows);
      return (int'(x) < cols) && (int'(y) < rows);
   endfunction

endpackage

// File: rtl/trail_writer_row_bit_patch.sv
// Combinational row patcher: reports the 2-bit code at a column of a
// plane pair and returns the same rows with a new code inserted there.
module row_bit_patch
   import trail_writer_pkg::*;
#(
   parameter int COLS = MAP_COLS_DEF
) (
   input  logic [COLS-1:0]    row_lsb_i,
   input  logic [COLS-1:0]    row_msb_i,
   input  logic [COORD_W-1:0] col_i,
   input  logic [1:0]         code_i,
   output logic [1:0]         code_o,
   output logic [COLS-1:0]    row_lsb_o,
   output logic [COLS-1:0]    row_msb_o
);

   logic [COORD_W-1:0] bit_idx;

   // Pixel 0 is the leftmost (most significant) bit of each row.
   assign bit_idx = COORD_W'(COLS - 1) - col_i;
   assign code_o  = {row_msb_i[bit_idx], row_lsb_i[bit_idx]};

   always_comb begin
      row_lsb_o          = row_lsb_i;
      row_msb_o          = row_msb_i;
      row_lsb_o[bit_idx] = code_i[0];
      row_msb_o[bit_idx] = code_i[1];
   end

endmodule

// File: rtl/trail_writer.sv
// Trail writer: accepts player positions, reads the map row, and either
// paints a trail pixel, signals a closed loop, or signals a self-collision.
module trail_writer
   import trail_writer_pkg::*;
#(
   parameter int MAP_COLS = MAP_COLS_DEF,
   parameter int MAP_ROWS = MAP_ROWS_DEF
) (
   input  logic                clk,
   input  logic                clear,
   input  logic                move_valid,
   output logic                move_ready,
   input  logic [COORD_W-1:0]  pos_x,
   input  logic [COORD_W-1:0]  pos_y,
   input  logic                fill_busy,
   output logic [COORD_W-1:0]  rd_addr,
   input  logic [MAP_COLS-1:0] rd_data1,
   input  logic [MAP_COLS-1:0] rd_data2,
   output logic                wr_en,
   output logic [COORD_W-1:0]  wr_addr,
   output logic [MAP_COLS-1:0] wr_data1,
   output logic [MAP_COLS-1:0] wr_data2,
   output logic                loop_closed,
   output logic                collision,
   output logic                range_err
);

   tw_state_e          state_q, state_d;
   logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
   logic [COORD_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
   logic [COORD_W-1:0] last_x_q, last_x_d, last_y_q, last_y_d;
   logic               last_valid_q, last_valid_d;
   logic               trail_active_q, trail_active_d;
   logic               wr_en_q, wr_en_d, loop_q, loop_d;
   logic               coll_q, coll_d, range_q, range_d;
   logic [MAP_COLS-1:0] wr_data1_q, wr_data1_d, wr_data2_q, wr_data2_d;
   logic [MAP_COLS-1:0] patched1, patched2;
   logic [1:0]          cur_code;
   logic                accept;

   assign move_ready = (state_q == ST_IDLE) && !fill_busy;
   assign accept     = move_valid && move_ready;

   row_bit_patch #(.COLS(MAP_COLS)) u_patch (
      .row_lsb_i (rd_data1),
      .row_msb_i (rd_data2),
      .col_i     (x_q),
      .code_i    (PIX_TRAIL),
      .code_o    (cur_code),
      .row_lsb_o (patched1),
      .row_msb_o (patched2)
   );

   always_comb begin
      // NOTE: every variable gets its hold/idle value first, so a branch that skips it cannot infer a latch.
      state_d        = state_q;
      x_d            = x_q;
      y_d            = y_q;
      rd_addr_d      = rd_addr_q;
      wr_addr_d      = wr_addr_q;
      wr_data1_d     = wr_data1_q;
      wr_data2_d     = wr_data2_q;
      last_x_d       = last_x_q;
      last_y_d       = last_y_q;
      last_valid_d   = last_valid_q;
      trail_active_d = trail_active_q;
      wr_en_d        = 1'b0;
      loop_d         = 1'b0;
      coll_d         = 1'b0;
      range_d        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               x_d = pos_x;
               y_d = pos_y;
               if (!coord_in_map(pos_x, pos_y, MAP_COLS, MAP_ROWS)) begin
                  range_d = 1'b1;
               end else if (!(last_valid_q && pos_x == last_x_q && pos_y == last_y_q)) begin
                  rd_addr_d = pos_y;
                  state_d   = ST_WAIT;
               end
            end
         end
         ST_WAIT:  state_d = ST_CHECK;
         ST_CHECK: begin
            state_d = ST_WRITE;
            // The row read issued in WAIT is on rd_data during this cycle.
            case (pix_code_e'(cur_code))
               PIX_UNSHADED, PIX_UNKNOWN: begin
                  wr_en_d        = 1'b1;
                  wr_addr_d      = y_q;
                  wr_data1_d     = patched1;
                  wr_data2_d     = patched2;
                  trail_active_d = 1'b1;
                  last_x_d       = x_q;
                  last_y_d       = y_q;
                  last_valid_d   = 1'b1;
               end
               PIX_BORDER: begin
                  if (trail_active_q) begin
                     loop_d         = 1'b1;
                     trail_active_d = 1'b0;
                  end
               end
               default: begin
                  coll_d         = 1'b1;
                  trail_active_d = 1'b0;
               end
            endcase
         end
         ST_WRITE: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_q        <= ST_IDLE;
         x_q            <= '0;
         y_q            <= '0;
         rd_addr_q      <= '0;
         wr_addr_q      <= '0;
         wr_data1_q     <= '0;
         wr_data2_q     <= '0;
         last_x_q       <= '0;
         last_y_q       <= '0;
         last_valid_q   <= 1'b0;
         trail_active_q <= 1'b0;
         wr_en_q        <= 1'b0;
         loop_q         <= 1'b0;
         coll_q         <= 1'b0;
         range_q        <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
         state_q        <= state_d;
         x_q            <= x_d;
         y_q            <= y_d;
         rd_addr_q      <= rd_addr_d;
         wr_addr_q      <= wr_addr_d;
         wr_data1_q     <= wr_data1_d;
         wr_data2_q     <= wr_data2_d;
         last_x_q       <= last_x_d;
         last_y_q       <= last_y_d;
         last_valid_q   <= last_valid_d;
         trail_active_q <= trail_active_d;
         wr_en_q        <= wr_en_d;
         loop_q         <= loop_d;
         coll_q         <= coll_d;
         range_q        <= range_d;
      end
   end

   assign rd_addr     = rd_addr_q;
   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data1    = wr_data1_q;
   assign wr_data2    = wr_data2_q;
   assign loop_closed = loop_q;
   assign collision   = coll_q;
   assign range_err   = range_q;

endmodule

// File: tb/tb_trail_writer.sv
// Scoreboard bench for trail_writer: a pixel-map model predicts each move's
// outcome, a monitor matches every output pulse against the queue.
module tb_trail_writer;
   import trail_writer_pkg::*;

   localparam int COLS   = 800;
   localparam int ROWS   = 600;
   localparam int K_WR   = 0;
   localparam int K_LOOP = 1;
   localparam int K_COLL = 2;
   localparam int K_RNG  = 3;

   logic            clk = 1'b0;
   logic            clear, move_valid, fill_busy, move_ready;
   logic [9:0]      pos_x, pos_y, rd_addr, wr_addr;
   logic            wr_en, loop_closed, collision, range_err;
   logic [COLS-1:0] rd_data1, rd_data2, wr_data1, wr_data2;

   always #5 clk = ~clk;

   trail_writer #(.MAP_COLS(COLS), .MAP_ROWS(ROWS)) dut (
      .clk(clk), .clear(clear), .move_valid(move_valid), .move_ready(move_ready),
      .pos_x(pos_x), .pos_y(pos_y), .fill_busy(fill_busy), .rd_addr(rd_addr),
      .rd_data1(rd_data1), .rd_data2(rd_data2), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data1(wr_data1), .wr_data2(wr_data2), .loop_closed(loop_closed),
      .collision(collision), .range_err(range_err)
   );

   // Map memory (environment): 1-cycle synchronous read, backdoor loads.
   logic [COLS-1:0] mem1 [ROWS];
   logic [COLS-1:0] mem2 [ROWS];
   logic            bd_req = 1'b0;
   int              bd_row = 0;
   logic [COLS-1:0] bd_d1, bd_d2;

   always @(posedge clk) begin
      if (bd_req) begin
         mem1[bd_row] <= bd_d1;
         mem2[bd_row] <= bd_d2;
      end else if (wr_en && int'(wr_addr) < ROWS) begin
         mem1[wr_addr] <= wr_data1;
         mem2[wr_addr] <= wr_data2;
      end
      rd_data1 <= (int'(rd_addr) < ROWS) ? mem1[rd_addr] : '0;
      rd_data2 <= (int'(rd_addr) < ROWS) ? mem2[rd_addr] : '0;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_row(input string name, input logic [COLS-1:0] act, input logic [COLS-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: map as a grid of pixel codes plus the move rules.
   logic [1:0] pix [ROWS][COLS];
   bit         m_trail, m_last_valid;
   int         m_lx, m_ly, exp_rd;

   typedef struct {
      int              kind;
      int              cyc;
      int              addr;
      logic [COLS-1:0] d2;
      logic [COLS-1:0] d1;
   } exp_t;
   exp_t exp_q[$];

   function automatic void row_of(input int y, output logic [COLS-1:0] d2, output logic [COLS-1:0] d1);
      for (int c = 0; c < COLS; c++) begin
         d2[COLS-1-c] = pix[y][c][1];
         d1[COLS-1-c] = pix[y][c][0];
      end
   endfunction

   task automatic predict(input int x, input int y, input int c0);
      logic [COLS-1:0] r2, r1;
      if (x >= COLS || y >= ROWS) begin
         exp_q.push_back('{kind: K_RNG, cyc: c0 + 1, addr: 0, d2: '0, d1: '0});
      end else if (m_last_valid && x == m_lx && y == m_ly) begin
         // repeated last trail pixel: no effect
      end else begin
         exp_rd = y;
         case (pix[y][x])
            2'b00, 2'b01: begin
               pix[y][x] = 2'b10;
               row_of(y, r2, r1);
               exp_q.push_back('{kind: K_WR, cyc: c0 + 3, addr: y, d2: r2, d1: r1});
               m_trail      = 1'b1;
               m_last_valid = 1'b1;
               m_lx         = x;
               m_ly         = y;
            end
            2'b11: begin
               if (m_trail) exp_q.push_back('{kind: K_LOOP, cyc: c0 + 3, addr: 0, d2: '0, d1: '0});
               m_trail = 1'b0;
            end
            default: begin
               exp_q.push_back('{kind: K_COLL, cyc: c0 + 3, addr: 0, d2: '0, d1: '0});
               m_trail = 1'b0;
            end
         endcase
      end
   endtask

   // Monitor: every pulse must match the head of the expected queue.
   always @(negedge clk) begin : monitor
      int   hi, kind;
      exp_t e;
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         e = exp_q.pop_front();
         check("missed_event_kind", -1, e.kind);
      end
      hi = int'(wr_en) + int'(loop_closed) + int'(collision) + int'(range_err);
      if (hi > 1) begin
         check("pulse_onehot", hi, 1);
      end else if (hi == 1) begin
         kind = wr_en ? K_WR : loop_closed ? K_LOOP : collision ? K_COLL : K_RNG;
         if (exp_q.size() == 0) begin
            check("unexpected_pulse_kind", kind, -1);
         end else begin
            e = exp_q.pop_front();
            check("evt_kind", kind, e.kind);
            check("evt_cycle", cyc, e.cyc);
            if (kind == K_WR && e.kind == K_WR) begin
               check("wr_addr", int'(wr_addr), e.addr);
               check_row("wr_data2", wr_data2, e.d2);
               check_row("wr_data1", wr_data1, e.d1);
            end
         end
      end
   end

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (move_ready === 1'b1) begin
            ok = 1'b1;
            return;
         end
      end
      check("ready_timeout", 0, 1);
   endtask

   task automatic load_row(input int y);
      logic [COLS-1:0] r2, r1;
      row_of(y, r2, r1);
      bd_row = y;
      bd_d2  = r2;
      bd_d1  = r1;
      bd_req = 1'b1;
      @(negedge clk);
      bd_req = 1'b0;
   endtask

   task automatic set_pix(input int x, input int y, input logic [1:0] c);
      bit ok;
      wait_ready(ok);
      pix[y][x] = c;
      load_row(y);
   endtask

   task automatic do_move(input int x, input int y, input int pre, input int post);
      bit ok;
      wait_ready(ok);
      if (!ok) return;
      pos_x      = 10'(x);
      pos_y      = 10'(y);
      move_valid = 1'b1;
      if (pre > 0) begin
         fill_busy = 1'b1;
         for (int i = 0; i < pre; i++) begin
            @(negedge clk);
            check("ready_while_busy", int'(move_ready), 0);
            check("rd_addr_while_busy", int'(rd_addr), exp_rd);
         end
         fill_busy = 1'b0;
      end
      predict(x, y, cyc);
      @(negedge clk);
      move_valid = 1'b0;
      check("rd_addr_after_accept", int'(rd_addr), exp_rd);
      if (post > 0) begin
         fill_busy = 1'b1;
         repeat (post) @(negedge clk);
         fill_busy = 1'b0;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int  x, y, r, pre, post;
      bit  ok;
      clear      = 1'b1;
      move_valid = 1'b0;
      fill_busy  = 1'b0;
      pos_x      = '0;
      pos_y      = '0;
      m_trail = 1'b0; m_last_valid = 1'b0; m_lx = 0; m_ly = 0; exp_rd = 0;

      for (int yy = 0; yy < ROWS; yy++)
         for (int xx = 0; xx < COLS; xx++)
            pix[yy][xx] = (yy == 0 || xx == 0 || yy == ROWS-1 || xx == COLS-1) ? 2'b11 : 2'($urandom_range(0, 1));
      for (int xx = 0; xx < COLS; xx++) pix[5][xx] = 2'b00;
      for (int yy = 0; yy < ROWS; yy++) load_row(yy);

      // Reset state
      @(negedge clk);
      check("rst_wr_en", int'(wr_en), 0);
      check("rst_loop_closed", int'(loop_closed), 0);
      check("rst_collision", int'(collision), 0);
      check("rst_range_err", int'(range_err), 0);
      check("rst_rd_addr", int'(rd_addr), 0);
      check("rst_wr_addr", int'(wr_addr), 0);
      check_row("rst_wr_data2", wr_data2, '0);
      check("rst_move_ready", int'(move_ready), 1);
      clear = 1'b0;

      // Directed scenarios
      do_move(10, 5, 0, 0);           // paint on 00 row
      set_pix(11, 5, 2'b11);
      do_move(11, 5, 0, 0);           // border with trail active -> loop
      do_move(10, 5, 0, 0);           // last trail pixel -> ignored
      do_move(12, 5, 0, 0);
      do_move(10, 5, 0, 0);           // own trail -> collision
      do_move(800, 3, 0, 0);          // out of range
      check("ready_after_range", int'(move_ready), 1);
      do_move(3, 600, 0, 0);
      do_move(40, 9, 3, 0);           // held off by fill_busy
      do_move(41, 9, 0, 3);           // fill_busy during flight

      // clear during CHECK aborts the write and drops trail_active
      do_move(30, 8, 0, 0);
      wait_ready(ok);
      pos_x = 10'd31; pos_y = 10'd8; move_valid = 1'b1;
      @(negedge clk);
      move_valid = 1'b0;
      @(negedge clk);
      clear = 1'b1;
      m_trail = 1'b0; m_last_valid = 1'b0; exp_rd = 0;
      @(negedge clk);
      check("clear_rd_addr", int'(rd_addr), 0);
      check("clear_ready", int'(move_ready), 1);
      clear = 1'b0;
      set_pix(32, 8, 2'b11);
      do_move(32, 8, 0, 0);           // border, trail inactive -> nothing

      // Randomised moves near the top-left corner of the map
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 99);
         x = $urandom_range(0, 14);
         y = $urandom_range(0, 14);
         if (r < 5) x = $urandom_range(COLS, 1023);
         else if (r < 9) y = $urandom_range(ROWS, 1023);
         else if (r < 15) set_pix(x, y, 2'b11);
         else if (r < 22 && m_last_valid) begin
            x = m_lx;
            y = m_ly;
         end
         pre  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
         post = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
         do_move(x, y, pre, post);
      end

      repeat (10) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
